// File: rtl/ili_window_writer.sv
// Drives the shared ILI9341 byte shifter to draw one window: CASET, PASET, RAMWR, then RGB565 pixel bytes.
// Optional build macro ILI_WIN_SKIP_ADDR_EN skips re-sending an address pair equal to the last completed window's.
module ili_window_writer #(
  parameter int WIDTH   = 240,
  parameter int HEIGHT  = 320,
  parameter int GAP_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [15:0] i_x0,
  input  logic [15:0] i_x1,
  input  logic [15:0] i_y0,
  input  logic [15:0] i_y1,
  input  logic [15:0] i_pix,
  input  logic        i_pix_valid,
  output logic        o_pix_ready,
  input  logic        i_byte_done,
  output logic        o_send,
  output logic [7:0]  o_byte,
  output logic        o_dc,
  output logic        o_cs,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [2:0]  dbg_state
);

  // Handshake: i_pix is taken in the cycle i_pix_valid && o_pix_ready; o_send is a one-cycle load
  // strobe, o_byte/o_dc stay stable until the shifter answers with a one-cycle i_byte_done.

  localparam int CW = $clog2(WIDTH * HEIGHT + 1);
  localparam int GW = (GAP_CYC < 2) ? 1 : $clog2(GAP_CYC);

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT_DONE, GAP, PIX_WAIT, DONE} state_t;

  state_t          state_q, state_n;
  logic [3:0]      idx_q, idx_n;
  logic            pix_phase_q, pix_phase_n;
  logic            lo_q, lo_n;
  logic [15:0]     pix_q, pix_n;
  logic [CW-1:0]   cnt_q, cnt_n;
  logic [GW-1:0]   gap_q, gap_n;
  logic [15:0]     x0_q, x1_q, y0_q, y1_q;
  logic [15:0]     x0_n, x1_n, y0_n, y1_n;
  logic [7:0]      byte_n;
  logic            dc_n;
  logic            err_n;
  logic            step;
  logic            win_ok;

`ifdef ILI_WIN_SKIP_ADDR_EN
  logic            cache_vld_q;
  logic [15:0]     cx0_q, cx1_q, cy0_q, cy1_q;
  logic            skip_x;
  logic            skip_y_q, skip_y_n;
`endif

  assign dbg_state = state_q;
  assign win_ok = (i_x0 <= i_x1) && (i_x1 < 16'(WIDTH)) &&
                  (i_y0 <= i_y1) && (i_y1 < 16'(HEIGHT));

  function automatic logic [7:0] setup_byte(input logic [3:0] idx, input logic [15:0] x0,
                                            input logic [15:0] x1, input logic [15:0] y0,
                                            input logic [15:0] y1);
    logic [7:0] b;
    case (idx)
      4'd0:    b = 8'h2A;
      4'd1:    b = x0[15:8];
      4'd2:    b = x0[7:0];
      4'd3:    b = x1[15:8];
      4'd4:    b = x1[7:0];
      4'd5:    b = 8'h2B;
      4'd6:    b = y0[15:8];
      4'd7:    b = y0[7:0];
      4'd8:    b = y1[15:8];
      4'd9:    b = y1[7:0];
      default: b = 8'h2C;
    endcase
    return b;
  endfunction

  always_comb begin
    state_n     = state_q;
    idx_n       = idx_q;
    pix_phase_n = pix_phase_q;
    lo_n        = lo_q;
    pix_n       = pix_q;
    cnt_n       = cnt_q;
    gap_n       = gap_q;
    x0_n        = x0_q;
    x1_n        = x1_q;
    y0_n        = y0_q;
    y1_n        = y1_q;
    byte_n      = o_byte;
    dc_n        = o_dc;
    err_n       = 1'b0;
    step        = 1'b0;
    o_pix_ready = 1'b0;
`ifdef ILI_WIN_SKIP_ADDR_EN
    skip_x      = 1'b0;
    skip_y_n    = skip_y_q;
`endif

    case (state_q)
      IDLE: begin
        if (i_start) begin
          if (win_ok) begin
            x0_n    = i_x0;
            x1_n    = i_x1;
            y0_n    = i_y0;
            y1_n    = i_y1;
            state_n = LOAD;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      LOAD: begin
        cnt_n       = CW'((32'(x1_q - x0_q) + 32'd1) * (32'(y1_q - y0_q) + 32'd1));
        pix_phase_n = 1'b0;
        lo_n        = 1'b0;
`ifdef ILI_WIN_SKIP_ADDR_EN
        skip_x   = cache_vld_q && (x0_q == cx0_q) && (x1_q == cx1_q);
        skip_y_n = cache_vld_q && (y0_q == cy0_q) && (y1_q == cy1_q);
        idx_n    = skip_x ? (skip_y_n ? 4'd10 : 4'd5) : 4'd0;
`else
        idx_n    = 4'd0;
`endif
        state_n = ISSUE;
      end
      ISSUE: state_n = WAIT_DONE;
      WAIT_DONE: begin
        if (i_byte_done) begin
          if (GAP_CYC == 0) begin
            step = 1'b1;
          end else begin
            gap_n   = '0;
            state_n = GAP;
          end
        end
      end
      GAP: begin
        if (int'(gap_q) + 1 >= GAP_CYC) step = 1'b1;
        else gap_n = gap_q + GW'(1);
      end
      PIX_WAIT: begin
        if (i_pix_valid) begin
          o_pix_ready = 1'b1;
          pix_n       = i_pix;
          lo_n        = 1'b0;
          state_n     = ISSUE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Decide what follows a finished byte (after its gap, if any).
    if (step) begin
      if (!pix_phase_q) begin
        if (idx_q < 4'd10) begin
`ifdef ILI_WIN_SKIP_ADDR_EN
          idx_n = (idx_q == 4'd4 && skip_y_q) ? 4'd10 : idx_q + 4'd1;
`else
          idx_n = idx_q + 4'd1;
`endif
          state_n = ISSUE;
        end else if (cnt_q != '0) begin
          pix_phase_n = 1'b1;
          lo_n        = 1'b0;
          state_n     = PIX_WAIT;
        end else begin
          state_n = DONE;
        end
      end else if (!lo_q) begin
        lo_n    = 1'b1;
        state_n = ISSUE;
      end else begin
        cnt_n   = cnt_q - CW'(1);
        lo_n    = 1'b0;
        state_n = (cnt_q == CW'(1)) ? DONE : PIX_WAIT;
      end
    end

    if (state_n == ISSUE) begin
      if (pix_phase_n) begin
        byte_n = lo_n ? pix_n[7:0] : pix_n[15:8];
        dc_n   = 1'b1;
      end else begin
        byte_n = setup_byte(idx_n, x0_q, x1_q, y0_q, y1_q);
        dc_n   = !((idx_n == 4'd0) || (idx_n == 4'd5) || (idx_n == 4'd10));
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      pix_phase_q <= 1'b0;
      lo_q        <= 1'b0;
      pix_q       <= '0;
      cnt_q       <= '0;
      gap_q       <= '0;
      x0_q        <= '0;
      x1_q        <= '0;
      y0_q        <= '0;
      y1_q        <= '0;
      o_send      <= 1'b0;
      o_byte      <= 8'h00;
      o_dc        <= 1'b1;
      o_cs        <= 1'b1;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      state_q     <= state_n;
      idx_q       <= idx_n;
      pix_phase_q <= pix_phase_n;
      lo_q        <= lo_n;
      pix_q       <= pix_n;
      cnt_q       <= cnt_n;
      gap_q       <= gap_n;
      x0_q        <= x0_n;
      x1_q        <= x1_n;
      y0_q        <= y0_n;
      y1_q        <= y1_n;
      o_send      <= (state_n == ISSUE);
      o_byte      <= byte_n;
      o_dc        <= dc_n;
      o_cs        <= !(state_n inside {ISSUE, WAIT_DONE, GAP, PIX_WAIT});
      o_busy      <= (state_n inside {ISSUE, WAIT_DONE, GAP, PIX_WAIT, DONE});
      o_done      <= (state_n == DONE);
      o_err       <= err_n;
    end
  end

`ifdef ILI_WIN_SKIP_ADDR_EN
  // The cache only reflects windows that actually completed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cache_vld_q <= 1'b0;
      cx0_q       <= '0;
      cx1_q       <= '0;
      cy0_q       <= '0;
      cy1_q       <= '0;
      skip_y_q    <= 1'b0;
    end else begin
      skip_y_q <= skip_y_n;
      if (state_q == DONE) begin
        cache_vld_q <= 1'b1;
        cx0_q       <= x0_q;
        cx1_q       <= x1_q;
        cy0_q       <= y0_q;
        cy1_q       <= y1_q;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ili_window_writer.sv
// Self-checking bench for ili_window_writer: shifter and pixel-source models plus a byte scoreboard.
module tb_ili_window_writer;
  localparam int WIDTH   = 240;
  localparam int HEIGHT  = 320;
  localparam int GAP_CYC = 2;

  logic        clk, rst;
  logic        i_start;
  logic [15:0] i_x0, i_x1, i_y0, i_y1;
  logic [15:0] i_pix;
  logic        i_pix_valid, o_pix_ready, i_byte_done;
  logic        o_send;
  logic [7:0]  o_byte;
  logic        o_dc, o_cs, o_busy, o_done, o_err;
  logic [2:0]  dbg_state;

  ili_window_writer #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .GAP_CYC(GAP_CYC)) dut (
    .clk(clk), .rst(rst), .i_start(i_start),
    .i_x0(i_x0), .i_x1(i_x1), .i_y0(i_y0), .i_y1(i_y1),
    .i_pix(i_pix), .i_pix_valid(i_pix_valid), .o_pix_ready(o_pix_ready),
    .i_byte_done(i_byte_done), .o_send(o_send), .o_byte(o_byte), .o_dc(o_dc),
    .o_cs(o_cs), .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .dbg_state(dbg_state)
  );

  int checks = 0;
  int failures = 0;

  logic [8:0]  exp_q[$];
  logic [15:0] src_q[$];
  logic [8:0]  e;

  int ack_lat = 8;
  int ack_cnt = 0;
  bit pix_en = 1'b1;
  bit taken = 1'b0;
  int done_cnt = 0, err_cnt = 0, ready_cnt = 0, cs_bad = 0;
  int win_sends = 0, cyc = 0, first_send_cyc = 0, start_cyc = 0;

  bit          m_vld = 1'b0;
  logic [15:0] m_x0, m_x1, m_y0, m_y1;
  logic [15:0] p_x0, p_x1, p_y0, p_y1;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- monitor + shifter/pixel models ----------------
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (o_send) begin
        win_sends++;
        if (win_sends == 1) first_send_cyc = cyc;
        check_eq("exp_avail", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq($sformatf("byte%0d", win_sends - 1), {o_dc, o_byte}, e);
        end
        ack_cnt = ack_lat;
      end
      if (o_pix_ready) begin
        ready_cnt++;
        taken = 1'b1;
      end
      if (o_done) begin
        done_cnt++;
        m_vld = 1'b1;
        m_x0 = p_x0; m_x1 = p_x1; m_y0 = p_y0; m_y1 = p_y1;
      end
      if (o_err) err_cnt++;
      if (o_busy && !o_done && o_cs) cs_bad++;
      @(posedge clk);
      #1;
      i_byte_done = 1'b0;
      if (!rst) begin
        ack_cnt = 0;
        taken = 1'b0;
      end else if (ack_cnt > 0) begin
        ack_cnt--;
        if (ack_cnt == 0) i_byte_done = 1'b1;
      end
      if (taken) begin
        if (src_q.size() != 0) void'(src_q.pop_front());
        taken = 1'b0;
      end
      i_pix_valid = pix_en && (src_q.size() != 0);
      i_pix = (src_q.size() != 0) ? src_q[0] : 16'h0000;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_setup(input logic [15:0] x0, input logic [15:0] x1,
                            input logic [15:0] y0, input logic [15:0] y1);
    logic [7:0] b[11];
    bit sx, sy;
    b = '{8'h2A, x0[15:8], x0[7:0], x1[15:8], x1[7:0],
          8'h2B, y0[15:8], y0[7:0], y1[15:8], y1[7:0], 8'h2C};
`ifdef ILI_WIN_SKIP_ADDR_EN
    sx = m_vld && x0 == m_x0 && x1 == m_x1;
    sy = m_vld && y0 == m_y0 && y1 == m_y1;
`else
    sx = 1'b0;
    sy = 1'b0;
`endif
    for (int i = 0; i < 11; i++) begin
      if (i < 5 && sx) continue;
      if (i >= 5 && i < 10 && sy) continue;
      exp_q.push_back({(i == 0 || i == 5 || i == 10) ? 1'b0 : 1'b1, b[i]});
    end
    p_x0 = x0; p_x1 = x1; p_y0 = y0; p_y1 = y1;
  endtask

  task automatic push_pixel(input logic [15:0] p);
    src_q.push_back(p);
    exp_q.push_back({1'b1, p[15:8]});
    exp_q.push_back({1'b1, p[7:0]});
  endtask

  task automatic load_window(input logic [15:0] x0, input logic [15:0] x1,
                             input logic [15:0] y0, input logic [15:0] y1, output int npix);
    push_setup(x0, x1, y0, y1);
    npix = (int'(x1) - int'(x0) + 1) * (int'(y1) - int'(y0) + 1);
    for (int k = 0; k < npix; k++) push_pixel(16'($urandom_range(0, 65535)));
  endtask

  task automatic start_win(input logic [15:0] x0, input logic [15:0] x1,
                           input logic [15:0] y0, input logic [15:0] y1);
    @(posedge clk);
    #2;
    i_x0 = x0; i_x1 = x1; i_y0 = y0; i_y1 = y1;
    i_start = 1'b1;
    @(negedge clk);
    #1;
    start_cyc = cyc;
    @(posedge clk);
    #2;
    i_start = 1'b0;
  endtask

  task automatic wait_sends(input int n, input int budget);
    for (int k = 0; k < budget && win_sends < n; k++) begin
      @(negedge clk);
      #1;
    end
    check_eq("sends_reached", win_sends >= n, 1);
  endtask

  task automatic wait_done(input int d0, input int budget);
    for (int k = 0; k < budget && done_cnt == d0; k++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic go(input logic [15:0] x0, input logic [15:0] x1, input logic [15:0] y0,
                    input logic [15:0] y1, input int npix, input int budget);
    int r0;
    int d0;
    r0 = ready_cnt;
    d0 = done_cnt;
    win_sends = 0;
    first_send_cyc = -100;
    cs_bad = 0;
    start_win(x0, x1, y0, y1);
    wait_done(d0, budget);
    check_eq("start_to_send", first_send_cyc - start_cyc, 2);
    check_eq("done_pulses", done_cnt - d0, 1);
    check_eq("pix_ready_pulses", ready_cnt - r0, npix);
    check_eq("exp_left", exp_q.size(), 0);
    check_eq("cs_high_while_busy", cs_bad, 0);
    @(negedge clk);
    #1;
    check_eq("busy_after_done", o_busy, 0);
    check_eq("cs_after_done", o_cs, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"}, o_busy, 0);
    check_eq({tag, "_done"}, o_done, 0);
    check_eq({tag, "_err"}, o_err, 0);
    check_eq({tag, "_send"}, o_send, 0);
    check_eq({tag, "_pix_ready"}, o_pix_ready, 0);
    check_eq({tag, "_byte"}, o_byte, 8'h00);
    check_eq({tag, "_dc"}, o_dc, 1);
    check_eq({tag, "_cs"}, o_cs, 1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n, e0, d0, s0, r0;
    rst = 1'b0;
    i_start = 1'b0;
    i_x0 = '0; i_x1 = '0; i_y0 = '0; i_y1 = '0;
    i_pix = '0;
    i_pix_valid = 1'b0;
    i_byte_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Two-pixel window with the reference byte stream.
    push_setup(16'd0, 16'd1, 16'd0, 16'd0);
    push_pixel(16'hA5F0);
    push_pixel(16'h1234);
    go(16'd0, 16'd1, 16'd0, 16'd0, 2, 3000);

    // Rejected windows.
    e0 = err_cnt;
    win_sends = 0;
    start_win(16'd5, 16'd4, 16'd0, 16'd0);
    repeat (3) @(negedge clk);
    #1;
    check_eq("err_x_order", err_cnt - e0, 1);
    check_eq("err_busy", o_busy, 0);
    start_win(16'd0, 16'd240, 16'd0, 16'd0);
    repeat (3) @(negedge clk);
    #1;
    check_eq("err_x_width", err_cnt - e0, 2);
    start_win(16'd0, 16'd0, 16'd0, 16'd320);
    repeat (3) @(negedge clk);
    #1;
    check_eq("err_y_height", err_cnt - e0, 3);
    check_eq("err_no_send", win_sends, 0);

    // Pixel source stalls for 50 cycles inside PIX_WAIT.
    pix_en = 1'b0;
    load_window(16'd3, 16'd3, 16'd7, 16'd7, n);
    d0 = done_cnt;
    win_sends = 0;
    start_win(16'd3, 16'd3, 16'd7, 16'd7);
    wait_sends(11, 1000);
    repeat (20) @(negedge clk);
    s0 = win_sends;
    r0 = ready_cnt;
    cs_bad = 0;
    repeat (50) @(negedge clk);
    #1;
    check_eq("stall_no_send", win_sends, s0);
    check_eq("stall_no_ready", ready_cnt, r0);
    check_eq("stall_cs_low", o_cs, 0);
    check_eq("stall_cs_held", cs_bad, 0);
    pix_en = 1'b1;
    wait_done(d0, 1000);
    check_eq("stall_done", done_cnt - d0, 1);
    check_eq("stall_ready", ready_cnt - r0, n);
    check_eq("stall_exp_left", exp_q.size(), 0);

    // Asynchronous reset during byte index 7, then a fresh window.
    load_window(16'd10, 16'd12, 16'd20, 16'd21, n);
    d0 = done_cnt;
    win_sends = 0;
    start_win(16'd10, 16'd12, 16'd20, 16'd21);
    wait_sends(8, 1000);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    src_q.delete();
    m_vld = 1'b0;
    repeat (3) @(negedge clk);
    // Start coinciding with reset must be dropped.
    @(posedge clk);
    #2;
    i_x0 = 16'd0; i_x1 = 16'd0; i_y0 = 16'd0; i_y1 = 16'd0;
    i_start = 1'b1;
    @(posedge clk);
    #2;
    i_start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    win_sends = 0;
    repeat (4) @(negedge clk);
    #1;
    check_eq("rst_start_busy", o_busy, 0);
    check_eq("rst_start_no_send", win_sends, 0);
    check_eq("midrst_no_done", done_cnt, d0);
    load_window(16'd1, 16'd1, 16'd2, 16'd2, n);
    go(16'd1, 16'd1, 16'd2, 16'd2, n, 3000);

    // Repeated and partly changed windows (address skipping when enabled).
    load_window(16'd20, 16'd30, 16'd40, 16'd41, n);
    go(16'd20, 16'd30, 16'd40, 16'd41, n, 8000);
    load_window(16'd20, 16'd30, 16'd40, 16'd41, n);
    go(16'd20, 16'd30, 16'd40, 16'd41, n, 8000);
    load_window(16'd20, 16'd30, 16'd40, 16'd45, n);
    go(16'd20, 16'd30, 16'd40, 16'd45, n, 8000);

    // Large window touching the right and bottom edges with a fast shifter.
    ack_lat = 1;
    load_window(16'd0, 16'd239, 16'd310, 16'd319, n);
    go(16'd0, 16'd239, 16'd310, 16'd319, n, 40000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ili_window_writer.md
Name: ili_window_writer

Overview:
- Sequences the ILI9341 SPI byte shifter to draw one rectangular window.
- Sends CASET (0x2A) with 4 column bytes, then PASET (0x2B) with 4 page bytes, then RAMWR (0x2C), then streams RGB565 pixels as high byte followed by low byte.
- Sits between the pixel source/frame logic and the shared byte shifter. Runs only after panel init has completed.

Parameters:
- WIDTH, 240, panel columns; the column coordinate must be below this.
- HEIGHT, 320, panel rows; the page coordinate must be below this.
- GAP_CYC, 2, idle clk cycles between i_byte_done and the next o_send; 0 is legal.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- i_start  in  1  one-cycle request to draw a window
- i_x0  in  16  first column
- i_x1  in  16  last column
- i_y0  in  16  first page
- i_y1  in  16  last page
- i_pix  in  16  RGB565 pixel
- i_pix_valid  in  1  i_pix is valid
- o_pix_ready  out  1  one-cycle pulse; i_pix is consumed this cycle
- i_byte_done  in  1  one-cycle pulse from the shifter; the outstanding byte has been shifted out
- o_send  out  1  one-cycle pulse; the shifter loads o_byte/o_dc
- o_byte  out  8  byte to shift
- o_dc  out  1  0 = command, 1 = data
- o_cs  out  1  panel chip select, active-low
- o_busy  out  1  a window is in progress
- o_done  out  1  one-cycle pulse; the window is complete
- o_err  out  1  one-cycle pulse; the start was rejected

Behaviour:

Reset values and reset mid-operation:
- Reset values: o_busy=0, o_done=0, o_err=0, o_send=0, o_pix_ready=0, o_byte=0x00, o_dc=1, o_cs=1; state IDLE; all counters 0.
- Reset mid-window forces every output to its reset value immediately. CS is released and there is no completion pulse.

States: IDLE, LOAD, ISSUE, WAIT_DONE, GAP, PIX_WAIT, DONE.

IDLE:
- On i_start=1, check the window: valid when x0<=x1<WIDTH and y0<=y1<HEIGHT. All comparisons are unsigned 16-bit.
- Invalid window: o_err=1 next cycle, stay IDLE, no other output changes.
- Valid window: latch the coordinates and go to LOAD.
- i_start while o_busy=1 is ignored.

LOAD:
- o_busy=1, o_cs=0.
- Byte index = 0.
- Pixel counter = (x1-x0+1)*(y1-y0+1), width clog2(WIDTH*HEIGHT+1).
- Go to ISSUE.

Byte order:
- Index 0..10 sends: 0x2A, x0[15:8], x0[7:0], x1[15:8], x1[7:0], 0x2B, y0[15:8], y0[7:0], y1[15:8], y1[7:0], 0x2C.
- o_dc=0 for indices 0, 5 and 10; o_dc=1 for all others.

ISSUE:
- o_send=1 for one cycle.
- o_byte and o_dc are driven the same cycle and held stable until i_byte_done.
- Go to WAIT_DONE.

WAIT_DONE:
- On i_byte_done, go to GAP, or straight to the next step when GAP_CYC=0.
- i_byte_done in any other state is ignored.

GAP:
- Counts GAP_CYC cycles.
- Then: if index<10, increment the index and go to ISSUE.
- After index 10: if pixel counter>0, go to PIX_WAIT.

PIX_WAIT:
- Holds o_cs=0 indefinitely while i_pix_valid=0.
- When i_pix_valid=1: o_pix_ready=1 for that cycle, latch i_pix, issue the high byte (dc=1).
- After the high byte plus gap, issue the low byte. No handshake is needed for the low byte.
- After the low byte: decrement the pixel counter. If the counter is 0, go to DONE; otherwise return to PIX_WAIT.

DONE:
- o_cs=1 and o_done=1 for one cycle, then IDLE with o_busy=0.

Latency:
- A valid i_start in cycle N gives o_cs=0 and o_busy=1 at N+2, and the first o_send at N+2.
- Steady state is one byte per shifter completion plus GAP_CYC+1 cycles.

Boundary conditions:
- A 1x1 window sends 11 setup bytes plus 2 pixel bytes.
- A full-screen window gives 76800 pixels with no counter overflow.
- i_start together with rst low: reset wins.
- i_pix_valid outside PIX_WAIT is never acknowledged.

Optional Feature:
- Macro ILI_WIN_SKIP_ADDR_EN.
- When defined:
  - The block stores the last sent x0/x1 and y0/y1. A valid flag is cleared by reset.
  - If the new x pair equals the stored pair and the flag is set, indices 0..4 are skipped. The same rule applies to the y pair and indices 5..9.
  - 0x2C is always sent.
  - Stored values update only when a window reaches DONE.
- When undefined: all 11 setup bytes are sent every window, with no extra registers.

Test Plan:
- Reset, start x0=0, x1=1, y0=0, y1=0, GAP_CYC=2, shifter ack 8 cycles after each o_send: bytes 2A 00 00 00 01 2B 00 00 00 00 2C followed by pixels A5F0 and 1234 as A5 F0 12 34. dc pattern 0,1,1,1,1,0,1,1,1,1,0,1,1,1,1; o_pix_ready pulses twice; o_done once; o_cs low throughout.
- Start x0=5, x1=4: o_err pulses once, o_busy stays 0, no o_send. Then start x1=240 with WIDTH=240: o_err pulses again.
- In PIX_WAIT, hold i_pix_valid=0 for 50 cycles: no o_send, o_cs stays 0, o_pix_ready stays 0; resumes correctly once valid rises.
- Assert rst low during byte index 7: all outputs return to reset values asynchronously. A new start after reset emits 0x2A first.
- Full window 0..239 x 0..319 with a fast shifter: exactly 153600 pixel data bytes, o_done once.
- With ILI_WIN_SKIP_ADDR_EN, two identical windows back-to-back: the second emits only 0x2C plus pixels. Change y1: the second emits 2B, four y bytes, 2C.
